// File: rtl/av2_tile_bitstream_feeder.sv
// rtl/av2_tile_bitstream_feeder.sv - packs a byte stream into 128-bit tile words
//
// Purpose:
//   Accepts a frame of frame_bytes bitstream bytes and packs them
//   little-endian into 128-bit words (byte k in bits [8k+7:8k]). A final
//   partial word is zero-padded and flagged with tile_last.
//
// Configuration macro:
//   AV2_FEEDER_SKID_EN - adds a second 128-bit holding register so packing
//   can continue while the output word waits on tile_ready.
//
// Ports:
//   clk, rst                 - rising-edge clock, synchronous active-high reset
//   start, frame_bytes       - frame start pulse and payload length (IDLE only)
//   in_byte/in_valid/in_ready - byte input stream
//   tile_data/tile_valid/tile_ready/tile_last - 128-bit word output stream
//   busy, frame_done         - status: not idle / one-cycle completion pulse
//   bytes_accepted, words_sent - per-frame handshake counters
module av2_tile_bitstream_feeder #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_bytes,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     tile_data,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic             tile_last,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] bytes_accepted,
    output logic [CNT_W-1:0] words_sent
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [127:0]     pack_q, pack_d;
    logic [127:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
`ifdef AV2_FEEDER_SKID_EN
    logic [127:0]     hold_data_q, hold_data_d;
    logic             hold_valid_q, hold_valid_d;
    logic             hold_last_q, hold_last_d;
    logic             load;
`endif

    logic             final_byte;
    logic             completing;
    logic             out_free;
    logic             in_ready_c;
    logic             in_hs;
    logic             out_hs;
    logic [127:0]     word_next;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bytes_d     = bytes_q;
        words_d     = words_q;
        byte_idx_d  = byte_idx_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef AV2_FEEDER_SKID_EN
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
`endif

        final_byte = ((bytes_q + CNT_W'(1)) == len_q);
        completing = (byte_idx_q == 4'd15) || final_byte;
        // The output register can take a new word if empty or draining now.
        out_free   = !out_valid_q || tile_ready;

        // Packing register with the incoming byte merged into its lane.
        word_next = pack_q;
        word_next[{byte_idx_q, 3'b000} +: 8] = in_byte;

`ifdef AV2_FEEDER_SKID_EN
        // Stall only if a completing byte has nowhere to go.
        in_ready_c = (state_q == PACK) && !(completing && hold_valid_q && !out_free);
`else
        in_ready_c = (state_q == PACK) && !(completing && !out_free);
`endif
        in_hs  = in_valid && in_ready_c;
        out_hs = out_valid_q && tile_ready;

        if (in_hs) begin
            bytes_d    = bytes_q + CNT_W'(1);
            byte_idx_d = byte_idx_q + 4'd1;
            if (completing) begin
                // Clearing here is what zero-pads a later partial word.
                pack_d = '0;
                if (final_byte) begin
                    byte_idx_d = 4'd0;
                end
            end else begin
                pack_d = word_next;
            end
        end
        if (out_hs) begin
            words_d = words_q + CNT_W'(1);
        end

`ifdef AV2_FEEDER_SKID_EN
        load = in_hs && completing;
        if (hold_valid_q) begin
            // Holding word always goes out first to preserve order.
            if (out_free) begin
                out_data_d  = hold_data_q;
                out_valid_d = 1'b1;
                out_last_d  = hold_last_q;
                if (load) begin
                    hold_data_d = word_next;
                    hold_last_d = final_byte;
                end else begin
                    hold_valid_d = 1'b0;
                    hold_last_d  = 1'b0;
                end
            end
        end else if (load) begin
            if (out_free) begin
                out_data_d  = word_next;
                out_valid_d = 1'b1;
                out_last_d  = final_byte;
            end else begin
                hold_data_d  = word_next;
                hold_valid_d = 1'b1;
                hold_last_d  = final_byte;
            end
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
`else
        if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        // A load in the same cycle as a handshake replaces the word directly.
        if (in_hs && completing) begin
            out_data_d  = word_next;
            out_valid_d = 1'b1;
            out_last_d  = final_byte;
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = frame_bytes;
                    bytes_d    = '0;
                    words_d    = '0;
                    byte_idx_d = 4'd0;
                    pack_d     = '0;
                    state_d    = (frame_bytes != '0) ? PACK : DONE;
                end
            end
            PACK: begin
                if (in_hs && final_byte) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            bytes_q     <= '0;
            words_q     <= '0;
            byte_idx_q  <= 4'd0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef AV2_FEEDER_SKID_EN
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bytes_q     <= bytes_d;
            words_q     <= words_d;
            byte_idx_q  <= byte_idx_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef AV2_FEEDER_SKID_EN
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
`endif
        end
    end

    assign in_ready       = in_ready_c;
    assign tile_data      = out_data_q;
    assign tile_valid     = out_valid_q;
    assign tile_last      = out_last_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);
    assign bytes_accepted = bytes_q;
    assign words_sent     = words_q;

endmodule

// File: tb/tb_av2_tile_bitstream_feeder.sv
// tb/tb_av2_tile_bitstream_feeder.sv - randomized self-checking bench for av2_tile_bitstream_feeder
module tb_av2_tile_bitstream_feeder;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] frame_bytes;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     tile_data;
    logic             tile_valid;
    logic             tile_ready;
    logic             tile_last;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] bytes_accepted;
    logic [CNT_W-1:0] words_sent;

    always #5 clk = ~clk;

    av2_tile_bitstream_feeder #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .frame_bytes    (frame_bytes),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .tile_data      (tile_data),
        .tile_valid     (tile_valid),
        .tile_ready     (tile_ready),
        .tile_last      (tile_last),
        .busy           (busy),
        .frame_done     (frame_done),
        .bytes_accepted (bytes_accepted),
        .words_sent     (words_sent)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the frame's bytes and the words they must become.
    logic [7:0]   frame [0:4095];
    int           n_bytes = 0;
    logic [127:0] exp_w[$];

    int           sent_idx = 0;
    int           w_seen = 0;
    int           done_seen = 0;
    int           cyc = 0;
    int           acc16_cyc = -1;
    int           first_valid_cyc = -1;
    int           stall_left = 0;
    int           valid_mode = 0;
    int           ready_mode = 0;
    bit           skid_chk = 1'b0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    task automatic build_model(input int n, input int pattern);
        logic [127:0] w;
        n_bytes = n;
        for (int i = 0; i < n; i++) begin
            frame[i] = (pattern == 0) ? 8'(i) : 8'($urandom_range(0, 255));
        end
        exp_w.delete();
        for (int k = 0; k < (n + 15) / 16; k++) begin
            w = '0;
            for (int l = 0; l < 16; l++) begin
                if (k * 16 + l < n) w[l*8 +: 8] = frame[k * 16 + l];
            end
            exp_w.push_back(w);
        end
        sent_idx        = 0;
        w_seen          = 0;
        done_seen       = 0;
        acc16_cyc       = -1;
        first_valid_cyc = -1;
        prev_stall      = 1'b0;
    endtask

    // One clock: observe at the falling edge, drive just after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (skid_chk && busy && sent_idx < 32 && sent_idx < n_bytes)
            check_eq("skid_in_ready", in_ready, 1'b1);
        if (in_valid && in_ready) begin
            check_eq("accept_within_frame", sent_idx < n_bytes, 1'b1);
            sent_idx++;
            if (sent_idx == 16) acc16_cyc = cyc;
        end
        if (tile_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall) begin
            check_eq("hold_valid", tile_valid, 1'b1);
            check_eq("hold_data", tile_data, prev_data);
            check_eq("hold_last", tile_last, prev_last);
        end
        if (tile_valid && tile_ready) begin
            check_eq("word_in_range", w_seen < exp_w.size(), 1'b1);
            if (w_seen < exp_w.size()) begin
                check_eq("word_data", tile_data, exp_w[w_seen]);
                check_eq("word_last", tile_last, w_seen == exp_w.size() - 1);
            end
            w_seen++;
        end
        prev_stall = tile_valid && !tile_ready;
        prev_data  = tile_data;
        prev_last  = tile_last;
        if (prev_stall && stall_left > 0) stall_left--;
        if (frame_done) done_seen++;

        @(posedge clk);
        #1;
        in_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_byte  = (sent_idx < n_bytes) ? frame[sent_idx] : 8'hEE;
        case (ready_mode)
            0:       tile_ready = 1'b1;
            1:       tile_ready = 1'($urandom_range(0, 1));
            2:       tile_ready = 1'(cyc & 1);
            default: tile_ready = (stall_left == 0);
        endcase
    endtask

    task automatic run_frame(input int n, input int vmode, input int rmode,
                             input int pattern, input bit stray_start, input bit lat_chk);
        int  budget;
        bit  did_stray;
        build_model(n, pattern);
        valid_mode = vmode;
        ready_mode = rmode;
        stall_left = (rmode == 3) ? 20 : 0;
        did_stray  = 1'b0;
        start       = 1'b1;
        frame_bytes = n;
        step();
        start  = 1'b0;
        budget = n * 8 + 200;
        while (done_seen == 0 && budget > 0) begin
            if (stray_start && !did_stray && sent_idx >= 5) begin
                start       = 1'b1;
                frame_bytes = 7;
                did_stray   = 1'b1;
                step();
                start       = 1'b0;
                frame_bytes = n;
            end else begin
                step();
            end
            budget--;
        end
        step();
        step();
        check_eq("frame_done_once", done_seen, 1);
        check_eq("words_seen", w_seen, exp_w.size());
        check_eq("bytes_accepted", bytes_accepted, n);
        check_eq("words_sent", words_sent, exp_w.size());
        check_eq("bytes_offered_taken", sent_idx, n);
        check_eq("busy_after", busy, 1'b0);
        check_eq("tile_valid_after", tile_valid, 1'b0);
        if (lat_chk) check_eq("load_latency", first_valid_cyc - acc16_cyc, 1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        frame_bytes = '0;
        in_byte     = 8'h00;
        in_valid    = 1'b0;
        tile_ready  = 1'b0;
        n_bytes     = 0;
        step();
        step();
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_tile_valid", tile_valid, 1'b0);
        check_eq("rst_tile_last", tile_last, 1'b0);
        check_eq("rst_tile_data", tile_data, 128'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_bytes_accepted", bytes_accepted, 0);
        check_eq("rst_words_sent", words_sent, 0);
        rst = 1'b0;
        step();

        // 47 incrementing bytes, free-flowing output.
        run_frame(47, 0, 0, 0, 1'b0, 1'b1);
        // Long random frame with random back-pressure and a stray start.
        run_frame(3392, 1, 1, 1, 1'b1, 1'b0);
        // Output stalled for 20 valid cycles.
        run_frame(50, 0, 3, 1, 1'b0, 1'b0);

        // Zero-length frame.
        build_model(0, 0);
        valid_mode  = 0;
        ready_mode  = 0;
        start       = 1'b1;
        frame_bytes = 0;
        step();
        start = 1'b0;
        check_eq("zero_frame_done", frame_done, 1'b1);
        check_eq("zero_busy_done", busy, 1'b1);
        check_eq("zero_no_valid", tile_valid, 1'b0);
        step();
        check_eq("zero_frame_done_clr", frame_done, 1'b0);
        check_eq("zero_busy_clr", busy, 1'b0);
        check_eq("zero_no_valid2", tile_valid, 1'b0);
        step();

        // Reset after 20 of 47 bytes, then a fresh 16-byte frame.
        build_model(47, 1);
        start       = 1'b1;
        frame_bytes = 47;
        step();
        start = 1'b0;
        for (int b = 0; b < 200 && sent_idx < 20; b++) step();
        check_eq("mid_reset_reached", sent_idx >= 20, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        prev_stall = 1'b0;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_valid", tile_valid, 1'b0);
        check_eq("mid_rst_data", tile_data, 128'h0);
        check_eq("mid_rst_bytes", bytes_accepted, 0);
        step();
        run_frame(16, 0, 0, 1, 1'b0, 1'b0);

`ifdef AV2_FEEDER_SKID_EN
        skid_chk = 1'b1;
`endif
        run_frame(64, 0, 2, 1, 1'b0, 1'b0);
        skid_chk = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_frame($urandom_range(1, 80), $urandom_range(0, 1), $urandom_range(0, 2), 1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
